// File: rtl/raw_pattern_gen_if.sv
// Sensor-style video bus carried from the pattern source into the ISP front end:
// frame/line syncs, active-pixel qualifier and one 8-bit RAW sample per clock.
interface raw_pattern_gen_if;
   logic       out_vsync;
   logic       out_hsync;
   logic       out_den;
   logic [7:0] out_raw;

   modport master (output out_vsync, out_hsync, out_den, out_raw);
   modport slave  (input  out_vsync, out_hsync, out_den, out_raw);
endinterface

// File: rtl/raw_pattern_gen.sv
// Synthetic RGGB Bayer source with sensor-like raster timing, used in place of a
// camera for ISP bring-up. Every output is a registered decode of the raster counters.
module raw_pattern_gen #(
   parameter int SOURCE_H = 1024,
   parameter int SOURCE_V = 1024,
   parameter int H_BLANK  = 64,
   parameter int V_BLANK  = 16,
   parameter int HS_WIDTH = 8,
   parameter int VS_LINES = 2
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     enable,
   input  logic [1:0]               pattern_sel,
   raw_pattern_gen_if.master        vid,
   output logic [15:0]              frame_cnt,
   output logic                     busy
);
   localparam int LINE  = SOURCE_H + H_BLANK;
   localparam int FRAME = SOURCE_V + V_BLANK;
   // At least 8 bits so the ramp/checker slices always exist; +1 keeps sync end points representable.
   localparam int HW    = ($clog2(LINE + 1) < 8) ? 8 : $clog2(LINE + 1);
   localparam int VW    = ($clog2(FRAME + 1) < 8) ? 8 : $clog2(FRAME + 1);
   localparam int BAR_W = SOURCE_H / 8;
   localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

   localparam logic [HW-1:0] H_LAST     = HW'(LINE - 1);
   localparam logic [HW-1:0] H_ACT      = HW'(SOURCE_H);
   localparam logic [HW-1:0] H_SYNC_END = HW'(SOURCE_H + HS_WIDTH);
   localparam logic [VW-1:0] V_LAST     = VW'(FRAME - 1);
   localparam logic [VW-1:0] V_ACT      = VW'(SOURCE_V);
   localparam logic [VW-1:0] V_SYNC_END = VW'(SOURCE_V + VS_LINES);
   localparam logic [BW-1:0] BAR_LAST   = BW'(BAR_W - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [HW-1:0]   h_cnt_q, h_cnt_d;
   logic [VW-1:0]   v_cnt_q, v_cnt_d;
   logic [BW-1:0]   bar_pix_q, bar_pix_d;
   logic [2:0]      bar_idx_q, bar_idx_d;
   logic [1:0]      pat_q, pat_d;
   logic [15:0]     frame_cnt_q, frame_cnt_d;
   logic            vsync_q, vsync_d;
   logic            hsync_q, hsync_d;
   logic            den_q, den_d;
   logic [7:0]      raw_q, raw_d;

   logic            active;
   logic            line_wrap;
   logic            frame_wrap;
   logic            bar_on;
   logic [7:0]      pix;

   assign active     = (state_q != IDLE);
   assign line_wrap  = (h_cnt_q == H_LAST);
   assign frame_wrap = active && line_wrap && (v_cnt_q == V_LAST);

   // Leaving RUN exactly on the last raster clock means the frame is already whole,
   // so go straight to IDLE rather than draining an extra frame.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (enable) state_d = RUN;
         RUN:     if (!enable) state_d = frame_wrap ? IDLE : DRAIN;
         DRAIN:   if (enable) state_d = RUN;
                  else if (frame_wrap) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Raster counters plus a bar position counter that tracks h_cnt, avoiding a divider.
   always_comb begin
      h_cnt_d   = '0;
      v_cnt_d   = '0;
      bar_pix_d = '0;
      bar_idx_d = '0;
      if (active) begin
         if (line_wrap) begin
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
         end else begin
            h_cnt_d = h_cnt_q + 1'b1;
            v_cnt_d = v_cnt_q;
            if (bar_pix_q == BAR_LAST) begin
               bar_idx_d = bar_idx_q + 1'b1;
            end else begin
               bar_pix_d = bar_pix_q + 1'b1;
               bar_idx_d = bar_idx_q;
            end
         end
      end
   end

   always_comb begin
      pat_d       = pat_q;
      frame_cnt_d = frame_cnt_q;
      if (state_q == IDLE && enable) pat_d = pattern_sel;
      if (frame_wrap) begin
         pat_d       = pattern_sel;
         frame_cnt_d = frame_cnt_q + 16'd1;
      end
   end

   // Bar order white..black maps to {R,G,B} = ~{idx[1], idx[2], idx[0]}.
   always_comb begin
      bar_on = 1'b0;
      unique case ({v_cnt_q[0], h_cnt_q[0]})
         2'b00:   bar_on = ~bar_idx_q[1];
         2'b11:   bar_on = ~bar_idx_q[0];
         default: bar_on = ~bar_idx_q[2];
      endcase
   end

   always_comb begin
      pix = 8'h00;
      unique case (pat_q)
         2'd0:    pix = bar_on ? 8'hFF : 8'h00;
         2'd1:    pix = h_cnt_q[7:0] + v_cnt_q[7:0];
         2'd2:    pix = (h_cnt_q[4] ^ v_cnt_q[4]) ? 8'hFF : 8'h00;
         default: pix = frame_cnt_q[7:0];
      endcase
   end

   always_comb begin
      den_d   = active && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
      hsync_d = active && (h_cnt_q >= H_ACT) && (h_cnt_q < H_SYNC_END);
      vsync_d = active && (v_cnt_q >= V_ACT) && (v_cnt_q < V_SYNC_END);
      raw_d   = den_d ? pix : 8'h00;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         h_cnt_q     <= '0;
         v_cnt_q     <= '0;
         bar_pix_q   <= '0;
         bar_idx_q   <= '0;
         pat_q       <= '0;
         frame_cnt_q <= '0;
         vsync_q     <= 1'b0;
         hsync_q     <= 1'b0;
         den_q       <= 1'b0;
         raw_q       <= 8'h00;
      end else begin
         state_q     <= state_d;
         h_cnt_q     <= h_cnt_d;
         v_cnt_q     <= v_cnt_d;
         bar_pix_q   <= bar_pix_d;
         bar_idx_q   <= bar_idx_d;
         pat_q       <= pat_d;
         frame_cnt_q <= frame_cnt_d;
         vsync_q     <= vsync_d;
         hsync_q     <= hsync_d;
         den_q       <= den_d;
         raw_q       <= raw_d;
      end
   end

   assign vid.out_vsync = vsync_q;
   assign vid.out_hsync = hsync_q;
   assign vid.out_den   = den_q;
   assign vid.out_raw   = raw_q;
   assign frame_cnt     = frame_cnt_q;
   assign busy          = active;
endmodule
